data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 139 +++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a single-line
// eviction/refill memory port and hit/miss performance counters.
//
// state      | meaning
// IDLE       | serve hits; a miss goes to SWAP_OUT (dirty victim) or SWAP_IN
// SWAP_OUT   | write the victim line back, wait for mem_gnt
// SWAP_IN    | request the fill line, capture it on mem_gnt
// SWAP_IN_OK | install the captured line; the held request hits next cycle
module data_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int OFFSET_LEN    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   addr,
    input  logic                          rd_req,
    input  logic                          wr_req,
    input  logic [31:0]                   wr_data,
    output logic [31:0]                   rd_data,
    output logic                          miss,
    output logic                          mem_rd_req,
    output logic                          mem_wr_req,
    output logic [31:0]                   mem_addr,
    output logic [32*(2**OFFSET_LEN)-1:0] mem_wr_line,
    input  logic [32*(2**OFFSET_LEN)-1:0] mem_rd_line,
    input  logic                          mem_gnt,
    output logic [31:0]                   hit_cnt,
    output logic [31:0]                   miss_cnt
);
    localparam int NUM_LINES = 2 ** LINE_ADDR_LEN;
    localparam int WORDS     = 2 ** OFFSET_LEN;
    localparam int LINE_W    = 32 * WORDS;
    localparam int TAG_W     = 32 - LINE_ADDR_LEN - OFFSET_LEN - 2;

    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
    state_t state, state_nxt;

    logic [TAG_W-1:0]         tag_arr  [NUM_LINES];
    logic [31:0]              data_arr [NUM_LINES][WORDS];
    logic [NUM_LINES-1:0]     valid;
    logic [NUM_LINES-1:0]     dirty;
    logic [LINE_W-1:0]        fill_line;
    logic [TAG_W-1:0]         req_tag;
    logic [LINE_ADDR_LEN-1:0] req_set;

    logic [TAG_W-1:0]         cpu_tag;
    logic [LINE_ADDR_LEN-1:0] cpu_set;
    logic [OFFSET_LEN-1:0]    cpu_off;
    logic                     active;
    logic                     hit;
    logic                     req_miss;
    logic                     unused_byte;

    assign cpu_tag     = addr[31 -: TAG_W];
    assign cpu_set     = addr[OFFSET_LEN+2 +: LINE_ADDR_LEN];
    assign cpu_off     = addr[2 +: OFFSET_LEN];
    assign unused_byte = ^addr[1:0];

    assign active   = rd_req | wr_req;
    assign hit      = (state == IDLE) && active && valid[cpu_set] && (tag_arr[cpu_set] == cpu_tag);
    assign req_miss = (state == IDLE) && active && !hit;
    // A store wins when both requests are high, so only a pure load returns data.
    assign rd_data  = (hit && !wr_req) ? data_arr[cpu_set][cpu_off] : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        miss        = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = 32'd0;
        mem_wr_line = '0;
        case (state)
            IDLE: begin
                if (req_miss) begin
                    miss      = 1'b1;
                    state_nxt = (valid[cpu_set] && dirty[cpu_set]) ? SWAP_OUT : SWAP_IN;
                end
            end
            SWAP_OUT: begin
                miss       = 1'b1;
                mem_wr_req = 1'b1;
                mem_addr   = {tag_arr[req_set], req_set, {(OFFSET_LEN+2){1'b0}}};
                for (int w = 0; w < WORDS; w++) mem_wr_line[w*32 +: 32] = data_arr[req_set][w];
                if (mem_gnt) state_nxt = SWAP_IN;
            end
            SWAP_IN: begin
                miss       = 1'b1;
                mem_rd_req = 1'b1;
                mem_addr   = {req_tag, req_set, {(OFFSET_LEN+2){1'b0}}};
                if (mem_gnt) state_nxt = SWAP_IN_OK;
            end
            SWAP_IN_OK: begin
                miss      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid    <= '0;
            dirty    <= '0;
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
                if (wr_req) dirty[cpu_set] <= 1'b1;
            end
            if (req_miss) miss_cnt <= miss_cnt + 32'd1;
            if (state == SWAP_IN_OK) begin
                valid[req_set] <= 1'b1;
                dirty[req_set] <= 1'b0;
            end
        end
    end

    // Data and tag storage are not reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (req_miss) begin
                req_tag <= cpu_tag;
                req_set <= cpu_set;
            end
            if (hit && wr_req) data_arr[cpu_set][cpu_off] <= wr_data;
            if (state == SWAP_IN && mem_gnt) fill_line <= mem_rd_line;
            if (state == SWAP_IN_OK) begin
                tag_arr[req_set] <= req_tag;
                for (int w = 0; w < WORDS; w++) data_arr[req_set][w] <= fill_line[w*32 +: 32];
            end
        end
    end
endmodule
